// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared definitions for the data-side SRAM-like to AXI bridge:
// FSM state encoding, fixed AXI attribute values and the default master ID.
package data_sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_REQ,
        ST_WR_RESP
    } bridge_state_t;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_NONE = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE  = 3'd0;
    localparam int         DATA_ID_DEF    = 1;

    // SRAM size code (0/1/2) widened to the 3-bit AXI size field
    function automatic logic [2:0] axi_size(input logic [1:0] sz);
        return {1'b0, sz};
    endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Data-side SRAM-like responder to single-beat AXI master, one transaction
// in flight. Define DATA_BRIDGE_POSTED_WR_EN to acknowledge writes before B.
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int DATA_ID = DATA_ID_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            data_sram_req,
    input  logic            data_sram_wr,
    input  logic [1:0]      data_sram_size,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    input  logic [3:0]      data_sram_wstrb,
    output logic            data_sram_addr_ok,
    output logic            data_sram_data_ok,
    output logic [31:0]     data_sram_rdata,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    bridge_state_t r_state;
    logic [31:0]   r_addr;
    logic [1:0]    r_size;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_rdata;
    logic          r_arvalid;
    logic          r_rready;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_data_ok;
    logic          w_aw_done;
    logic          w_w_done;
    logic          w_unused;

    // a channel counts as done once its valid is low or handshakes now
    assign w_aw_done = ~r_awvalid | awready;
    assign w_w_done  = ~r_wvalid | wready;

`ifdef DATA_BRIDGE_POSTED_WR_EN
    logic r_rd_pend;
    logic w_rd_slot;
    // while waiting for B, one read may be taken and parked
    assign w_rd_slot = (r_state == ST_WR_RESP) & ~r_rd_pend
                     & ~data_sram_wr;
    assign data_sram_addr_ok = data_sram_req
                             & ((r_state == ST_IDLE) | w_rd_slot);
`else
    assign data_sram_addr_ok = data_sram_req & (r_state == ST_IDLE);
`endif

    assign data_sram_data_ok = r_data_ok;
    assign data_sram_rdata   = r_rdata;

    assign arid    = ID_W'(DATA_ID);
    assign araddr  = r_addr;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = axi_size(r_size);
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awid    = ID_W'(DATA_ID);
    assign awaddr  = r_addr;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = axi_size(r_size);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = AXI_CACHE_NONE;
    assign awprot  = AXI_PROT_NONE;
    assign awvalid = r_awvalid;

    assign wid    = ID_W'(DATA_ID);
    assign wdata  = r_wdata;
    assign wstrb  = r_wstrb;
    assign wlast  = 1'b1;
    assign wvalid = r_wvalid;
    assign bready = r_bready;

    // response IDs and status are not used for anything
    assign w_unused = ^{rid, rresp, rlast, bid, bresp};

    // request FSM with registered channel valids/readies and data_ok
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_data_ok <= 1'b0;
`ifdef DATA_BRIDGE_POSTED_WR_EN
            r_rd_pend <= 1'b0;
`endif
        end else begin
            r_data_ok <= 1'b0;
            if (data_sram_addr_ok) begin
                r_addr  <= data_sram_addr;
                r_size  <= data_sram_size;
                r_wdata <= data_sram_wdata;
                r_wstrb <= data_sram_wstrb;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (data_sram_req) begin
                        if (data_sram_wr) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        r_rready  <= 1'b0;
                        r_rdata   <= rdata;
                        r_data_ok <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (awready) r_awvalid <= 1'b0;
                    if (wready) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
`ifdef DATA_BRIDGE_POSTED_WR_EN
                        r_data_ok <= 1'b1;
`endif
                    end
                end
                ST_WR_RESP: begin
`ifdef DATA_BRIDGE_POSTED_WR_EN
                    if (data_sram_addr_ok) r_rd_pend <= 1'b1;
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        if (r_rd_pend || data_sram_addr_ok) begin
                            r_rd_pend <= 1'b0;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
`else
                    if (bvalid) begin
                        r_bready  <= 1'b0;
                        r_data_ok <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Bench for data_sram_axi_bridge: AXI slave with per-channel delays, an
// in-order reference memory model, a per-cycle compare and directed cases.
`timescale 1ns/1ps
module tb_data_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_sram_req = 1'b0;
    logic        data_sram_wr = 1'b0;
    logic [1:0]  data_sram_size = 2'd0;
    logic [31:0] data_sram_addr = '0;
    logic [31:0] data_sram_wdata = '0;
    logic [3:0]  data_sram_wstrb = '0;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arlock, awlock, rlast, wlast;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;

    assign rid = 4'd1;
    assign bid = 4'd1;
    assign rresp = 2'b00;
    assign bresp = 2'b00;
    assign rlast = 1'b1;

    always #5 clk = ~clk;

    data_sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // slave storage (written on AXI) and reference storage (written in order)
    logic [31:0] smem [int];
    logic [31:0] rmem [int];

    function automatic logic [31:0] dflt(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                          logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(logic [31:0] a);
        int k;
        k = int'(a[31:2]);
        return rmem.exists(k) ? rmem[k] : dflt({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] rd_slv(logic [31:0] a);
        int k;
        k = int'(a[31:2]);
        return smem.exists(k) ? smem[k] : dflt({a[31:2], 2'b00});
    endfunction

    // slave timing: a delay of N means valid/ready pairs on the Nth cycle
    int ar_dly = 1, r_dly = 1, aw_dly = 1, w_dly = 1, b_dly = 1;
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
    logic [31:0] r_addr_s = '0, aw_addr_s = '0, w_data_s = '0;
    logic [3:0]  w_strb_s = '0;

    // reference model of the request stream
    typedef struct packed { logic wr; logic [31:0] data; } resp_t;
    resp_t exp_q[$];
    bit m_rd_busy = 0, m_wr_busy = 0, m_wr_both = 0;
    bit exp_dok = 0, rst_seen = 0;
    bit p_ar_st = 0, p_aw_st = 0, p_w_st = 0, p_arv = 0;
    logic [31:0] c_rd_addr = '0, c_wr_addr = '0, c_wdata = '0;
    logic [1:0]  c_rd_size = '0, c_wr_size = '0;
    logic [3:0]  c_wstrb = '0;

    // observations used by the directed checks
    int cyc = 0, dok_cnt = 0, acc_cnt = 0, coincide = 0;
    int last_dok_cyc = 0, last_wr_dok = 0, acc_cyc = 0;
    int b_hs_cyc = 0, both_cyc = 0, ar_rise_cyc = 0;
    int aw_hi = 0, w_hi = 0;
    logic [31:0] dok_rdata = '0;
    logic [2:0]  arsize_seen = '0, awsize_seen = '0;

    always begin
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, both_now, can, exp_ok;
        resp_t e;
        @(negedge clk);
        cyc++;
        if (reset) begin
            exp_q.delete();
            {m_rd_busy, m_wr_busy, m_wr_both, exp_dok} = '0;
            {p_ar_st, p_aw_st, p_w_st, p_arv} = '0;
            {r_pend, b_pend, aw_got, w_got} = '0;
            {ar_wait, r_wait, aw_wait, w_wait, b_wait} = '0;
            rst_seen = 1;
        end else begin
            if (rst_seen) begin
                chk("rst_arvalid", arvalid, 0);
                chk("rst_awvalid", awvalid, 0);
                chk("rst_wvalid", wvalid, 0);
                chk("rst_rready", rready, 0);
                chk("rst_bready", bready, 0);
                chk("rst_data_ok", data_sram_data_ok, 0);
                chk("rst_rdata", data_sram_rdata, 0);
                chk("const_arlen", arlen, 0);
                chk("const_awburst", awburst, 2'b01);
                chk("const_wlast", wlast, 1);
                chk("const_wid", wid, 1);
                rst_seen = 0;
            end
            chk("data_ok", data_sram_data_ok, exp_dok);
            if (data_sram_data_ok) begin
                dok_cnt++;
                last_dok_cyc = cyc;
                dok_rdata = data_sram_rdata;
                chk("dok_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.wr) last_wr_dok = cyc;
                    else chk("rdata", data_sram_rdata, e.data);
                end
            end
            can = !m_rd_busy && !m_wr_busy;
`ifdef DATA_BRIDGE_POSTED_WR_EN
            if (m_wr_busy && m_wr_both && !m_rd_busy && !data_sram_wr)
                can = 1;
`endif
            exp_ok = data_sram_req && can;
            chk("addr_ok", data_sram_addr_ok, exp_ok);
            if (exp_ok && data_sram_data_ok) coincide++;
            chk("ar_after_b", arvalid && m_wr_busy, 0);
            if (p_ar_st) chk("arvalid_hold", arvalid, 1);
            if (p_aw_st) chk("awvalid_hold", awvalid, 1);
            if (p_w_st) chk("wvalid_hold", wvalid, 1);
            if (arvalid) begin
                chk("ar_in_read", m_rd_busy, 1);
                chk("araddr", araddr, c_rd_addr);
                chk("arsize", arsize, {1'b0, c_rd_size});
                arsize_seen = arsize;
                if (!p_arv) ar_rise_cyc = cyc;
            end
            if (awvalid) begin
                aw_hi++;
                chk("awaddr", awaddr, c_wr_addr);
                chk("awsize", awsize, {1'b0, c_wr_size});
                awsize_seen = awsize;
            end
            if (wvalid) begin
                w_hi++;
                chk("wdata", wdata, c_wdata);
                chk("wstrb", wstrb, c_wstrb);
            end
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            both_now = m_wr_busy && !m_wr_both &&
                       (aw_got || aw_hs) && (w_got || w_hs);
            if (both_now) both_cyc = cyc;
            if (b_hs) b_hs_cyc = cyc;
`ifdef DATA_BRIDGE_POSTED_WR_EN
            exp_dok = r_hs || both_now;
`else
            exp_dok = r_hs || b_hs;
`endif
            if (r_hs) m_rd_busy = 0;
            if (both_now) m_wr_both = 1;
            if (b_hs) begin
                m_wr_busy = 0;
                m_wr_both = 0;
            end
            if (exp_ok) begin
                acc_cnt++;
                acc_cyc = cyc;
                if (data_sram_wr) begin
                    m_wr_busy = 1;
                    c_wr_addr = data_sram_addr;
                    c_wr_size = data_sram_size;
                    c_wdata = data_sram_wdata;
                    c_wstrb = data_sram_wstrb;
                    rmem[int'(data_sram_addr[31:2])] =
                        merge(rd_ref(data_sram_addr), data_sram_wdata,
                              data_sram_wstrb);
                    exp_q.push_back('{1'b1, 32'h0});
                end else begin
                    m_rd_busy = 1;
                    c_rd_addr = data_sram_addr;
                    c_rd_size = data_sram_size;
                    exp_q.push_back('{1'b0, rd_ref(data_sram_addr)});
                end
            end
            p_ar_st = arvalid && !arready;
            p_aw_st = awvalid && !awready;
            p_w_st  = wvalid && !wready;
            p_arv   = arvalid;
            // slave bookkeeping for the coming edge
            if (r_hs) r_pend = 0;
            else if (r_pend && !rvalid) r_wait++;
            if (ar_hs) begin
                r_pend = 1;
                r_wait = 0;
                r_addr_s = araddr;
                ar_wait = 0;
            end else if (arvalid) ar_wait++;
            if (b_hs) b_pend = 0;
            else if (b_pend && !bvalid) b_wait++;
            if (aw_hs) begin
                aw_got = 1;
                aw_addr_s = awaddr;
                aw_wait = 0;
            end else if (awvalid) aw_wait++;
            if (w_hs) begin
                w_got = 1;
                w_data_s = wdata;
                w_strb_s = wstrb;
                w_wait = 0;
            end else if (wvalid) w_wait++;
            if (aw_got && w_got) begin
                smem[int'(aw_addr_s[31:2])] =
                    merge(rd_slv(aw_addr_s), w_data_s, w_strb_s);
                aw_got = 0;
                w_got = 0;
                b_pend = 1;
                b_wait = 0;
            end
        end
        @(posedge clk);
        #1;
        arready = arvalid && (ar_wait + 1 >= ar_dly);
        rvalid  = r_pend && (r_wait + 1 >= r_dly);
        rdata   = rvalid ? rd_slv(r_addr_s) : 32'h0;
        awready = awvalid && (aw_wait + 1 >= aw_dly);
        wready  = wvalid && (w_wait + 1 >= w_dly);
        bvalid  = b_pend && (b_wait + 1 >= b_dly);
    end

    task automatic issue(bit wr, logic [1:0] sz, logic [31:0] a,
                         logic [31:0] d, logic [3:0] s);
        int n;
        n = 0;
        data_sram_req = 1;
        data_sram_wr = wr;
        data_sram_size = sz;
        data_sram_addr = a;
        data_sram_wdata = d;
        data_sram_wstrb = s;
        do begin
            @(negedge clk);
            n++;
        end while (!data_sram_addr_ok && n < 60);
        if (n >= 60) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        data_sram_req = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || m_rd_busy || m_wr_busy) && n < 200);
        if (n >= 200) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, c0, n;
        smem[int'(32'h1000_0004 >> 2)] = 32'hDEAD_BEEF;
        rmem[int'(32'h1000_0004 >> 2)] = 32'hDEAD_BEEF;
        smem[int'(32'h1000_0000 >> 2)] = 32'h1122_3344;
        rmem[int'(32'h1000_0000 >> 2)] = 32'h1122_3344;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;

        // word read, slow AR and R
        ar_dly = 2;
        r_dly = 2;
        d0 = dok_cnt;
        issue(0, 2'd2, 32'h1000_0004, 0, 0);
        wait_done();
        chk("t1_rdata", dok_rdata, 32'hDEAD_BEEF);
        chk("t1_arsize", arsize_seen, 3'd2);
        chk("t1_dok_cnt", dok_cnt - d0, 1);
        chk("t1_latency", last_dok_cyc - acc_cyc, 5);
        ar_dly = 1;
        r_dly = 1;

        // fastest read: three cycles
        issue(0, 2'd2, 32'h1000_0000, 0, 0);
        wait_done();
        chk("t1b_rdata", dok_rdata, 32'h1122_3344);
        chk("t1b_latency", last_dok_cyc - acc_cyc, 3);

        // byte write, AW slow and W immediate
        aw_dly = 3;
        aw_hi = 0;
        w_hi = 0;
        d0 = dok_cnt;
        issue(1, 2'd0, 32'h1000_0003, 32'h5A5A_5A5A, 4'b1000);
        wait_done();
        chk("t2_awsize", awsize_seen, 3'd0);
        chk("t2_aw_cycles", aw_hi, 3);
        chk("t2_w_cycles", w_hi, 1);
        chk("t2_dok_cnt", dok_cnt - d0, 1);
`ifdef DATA_BRIDGE_POSTED_WR_EN
        chk("t2_dok_after_aw_w", last_wr_dok, both_cyc + 1);
`else
        chk("t2_dok_after_b", last_wr_dok, b_hs_cyc + 1);
`endif
        aw_dly = 1;
        issue(0, 2'd2, 32'h1000_0000, 0, 0);
        wait_done();
        chk("t2_readback", dok_rdata, 32'h5A22_3344);

        // write then read of the same word
        b_dly = 3;
        issue(1, 2'd2, 32'h1000_0008, 32'hCAFE_F00D, 4'hF);
        issue(0, 2'd2, 32'h1000_0008, 0, 0);
        wait_done();
        chk("t3_rdata", dok_rdata, 32'hCAFE_F00D);
        chk("t3_ar_after_b", ar_rise_cyc > b_hs_cyc, 1);
        b_dly = 1;

        // req held high: next accept lands on the data_ok cycle
        d0 = dok_cnt;
        c0 = coincide;
        n = acc_cnt;
        data_sram_req = 1;
        data_sram_wr = 0;
        data_sram_size = 2'd2;
        data_sram_addr = 32'h1000_0004;
        for (int i = 0; i < 40 && acc_cnt < n + 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t4_two_accepts", acc_cnt - n, 2);
        @(posedge clk);
        #1;
        data_sram_req = 0;
        wait_done();
        chk("t4_coincide", coincide - c0, 1);
        chk("t4_dok_cnt", dok_cnt - d0, 2);
        chk("t4_rdata", dok_rdata, 32'hDEAD_BEEF);

        // reset while waiting for R
        r_dly = 6;
        issue(0, 2'd2, 32'h1000_0004, 0, 0);
        n = 0;
        while (!rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_rdata", rready, 1);
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        r_dly = 1;
        d0 = dok_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_dok", dok_cnt - d0, 0);
        issue(0, 2'd1, 32'h1000_0004, 0, 0);
        wait_done();
        chk("t5_after_rst", dok_rdata, 32'hDEAD_BEEF);

        // write then read with a slow B
        b_dly = 5;
        issue(1, 2'd2, 32'h1000_000C, 32'h0BAD_CAFE, 4'hF);
        issue(0, 2'd2, 32'h1000_000C, 0, 0);
        wait_done();
        chk("t6_rdata", dok_rdata, 32'h0BAD_CAFE);
        chk("t6_ar_after_b", ar_rise_cyc > b_hs_cyc, 1);
`ifdef DATA_BRIDGE_POSTED_WR_EN
        chk("t6_wr_dok_before_b", last_wr_dok <= b_hs_cyc, 1);
`else
        chk("t6_wr_dok_after_b", last_wr_dok, b_hs_cyc + 1);
`endif
        b_dly = 1;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
Responder end of the data-side SRAM-like interface; the pipeline's EX stage issues requests and the MEM stage consumes data_ok/rdata. Converts each accepted request into one single-beat AXI3/AXI4 read (AR/R) or write (AW/W/B) on a dedicated data master port. Exactly one transaction is outstanding at a time, so responses are strictly in request order and read-after-write ordering is preserved without comparison logic.

Parameters:
ID_W, 4, AXI ID width.
DATA_ID, 1, constant ID driven on arid/awid; rid/bid are not checked.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
data_sram_req  in  1  request valid
data_sram_wr  in  1  1 = write, 0 = read
data_sram_size  in  2  0 = byte, 1 = half, 2 = word
data_sram_addr  in  32  byte address
data_sram_wdata  in  32  write data, lane-aligned
data_sram_wstrb  in  4  byte enables
data_sram_addr_ok  out  1  request accepted this cycle
data_sram_data_ok  out  1  one-cycle response pulse
data_sram_rdata  out  32  read data, valid while data_ok=1
AR: arid ID_W, araddr 32, arsize 3, arvalid 1 (out); arready 1 (in)
R: rid ID_W, rdata 32, rresp 2, rlast 1, rvalid 1 (in); rready 1 (out)
AW: awid ID_W, awaddr 32, awsize 3, awvalid 1 (out); awready 1 (in)
W: wdata 32, wstrb 4, wlast 1, wvalid 1 (out); wid ID_W (out, = DATA_ID); wready 1 (in)
B: bid ID_W, bresp 2, bvalid 1 (in); bready 1 (out)
Constant outputs: ar/awlen = 0, ar/awburst = 2'b01, ar/awlock = 0, ar/awcache = 0, ar/awprot = 0, wlast = 1.

Behaviour:
- Reset: state = IDLE. All valid/ready outputs = 0. addr_ok = 0, data_ok = 0, rdata = 0. Address and data registers = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - addr_ok = data_sram_req (combinational; acceptance is the req && addr_ok cycle).
  - On acceptance, latch addr, size, wdata and wstrb. Go to RD_ADDR if wr=0, otherwise WR_REQ.
- RD_ADDR:
  - arvalid = 1; araddr and arsize = {1'b0, size} stay stable until arready.
  - On the AR handshake, go to RD_DATA.
- RD_DATA:
  - rready = 1. On rvalid, register rdata and go to IDLE.
  - The next cycle, data_ok = 1 for exactly one cycle with rdata valid.
  - rresp and rid are ignored.
- WR_REQ:
  - awvalid and wvalid are raised together; each drops after its own handshake (flags aw_done, w_done).
  - Go to WR_RESP when both are done, including the same-cycle case.
- WR_RESP:
  - bready = 1. On bvalid, go to IDLE; data_ok pulses the next cycle.
  - rdata is don't-care and holds its previous value.
- Latency: minimum 3 cycles from acceptance to data_ok (AR/R each handshaking immediately).
- addr_ok = 0 in every non-IDLE state. A new request is accepted in the same cycle data_ok pulses (state is already IDLE).
- The bridge does not buffer responses; the consumer must capture the data_ok-cycle value.
- Valid signals never drop before their handshake.
- Reset mid-transaction aborts unconditionally. The AXI slave shares the reset.

Optional Feature:
DATA_BRIDGE_POSTED_WR_EN
- Defined: a write's data_ok pulses the cycle after both AW and W have handshaked; the state goes to WR_RESP and waits for B without another data_ok.
  - addr_ok for a following write may assert only after B.
  - A read accepted during WR_RESP is latched but its AR is withheld until bvalid.
- Undefined: data_ok for writes waits for B, as above.

Decomposition:
- Shared header: state encodings, AXI burst/size constants, DATA_ID default.
- No sub-module; one FSM plus channel flags.

Test Plan:
- Word read at 0x1000_0004: AXI slave returns 0xDEADBEEF with arready and rvalid after 2 cycles each -> arsize = 2, one data_ok pulse, rdata = 0xDEADBEEF, addr_ok low throughout.
- Byte write at 0x1000_0003, wstrb = 4'b1000, wdata = 0x5A5A5A5A; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, awsize = 0, data_ok the cycle after bvalid.
- Back-to-back: write then read of the same address -> AR is not issued before the B handshake; read returns the written data.
- req held high across a response -> second addr_ok coincides with the first data_ok; exactly one data_ok per request.
- Reset asserted in RD_DATA -> all valids and data_ok are 0 the next cycle, state IDLE, no spurious data_ok.
- DATA_BRIDGE_POSTED_WR_EN: write then read with bvalid delayed 5 cycles -> write data_ok before B; arvalid rises only after the B handshake.
